// File: rtl/mem_bus_arbiter.sv
// Shares one single-outstanding memory bus between the fetch port and the data port.
// Data wins by default; a run limit keeps fetch from starving; a watchdog bounds WAIT.
module mem_bus_arbiter #(
  parameter int MAX_DATA_RUN = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wsel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  output logic        inst_stall,
  output logic        data_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wsel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  wsel;
  } busReq_t;

  localparam int               RUN_W      = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(MAX_DATA_RUN);
  localparam logic [7:0]       WDOG_LIMIT = 8'(TIMEOUT);

  state_t           state;
  logic             ownerData;
  busReq_t          hold;
  logic [RUN_W-1:0] dataRun;
  logic [7:0]       wdog;
  logic [7:0]       wdogNext;
  logic             starve;
  logic             grantInst;
  logic             anyReq;
  busReq_t          reqInst;
  busReq_t          reqData;

  // A request whose ok is pulsing this cycle is the one just answered, not a new one;
  // this matters when a watchdog abort lands the ok pulse in IDLE.
  assign inst_stall = inst_req & ~inst_ok;
  assign data_stall = data_req & ~data_ok;

  assign starve    = inst_req && (dataRun == RUN_MAX);
  assign anyReq    = inst_stall | data_stall;
  assign grantInst = inst_stall & (~data_stall | starve);

  assign reqInst = '{addr: inst_addr, wdata: 32'h0, wr: 1'b0, wsel: 4'h0};
  assign reqData = '{addr: data_addr, wdata: data_wdata, wr: data_wr, wsel: data_wsel};

  assign bus_addr  = hold.addr;
  assign bus_wdata = hold.wdata;
  assign bus_wr    = hold.wr;
  assign bus_wsel  = hold.wsel;

  assign wdogNext = wdog + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ownerData  <= 1'b0;
      hold       <= '0;
      bus_req    <= 1'b0;
      dataRun    <= '0;
      wdog       <= '0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grantInst || !inst_req)
            dataRun <= '0;
          else if (data_stall && dataRun != RUN_MAX)
            dataRun <= dataRun + RUN_W'(1);
          if (anyReq) begin
            ownerData <= ~grantInst;
            hold      <= grantInst ? reqInst : reqData;
            bus_req   <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            wdog    <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            if (ownerData) begin
              data_rdata <= bus_rdata;
              data_ok    <= 1'b1;
            end else begin
              inst_rdata <= bus_rdata;
              inst_ok    <= 1'b1;
            end
            state <= RESP;
          end else if (wdogNext == WDOG_LIMIT) begin
            // abort: answer the owner with zero data so the pipeline unblocks
            bus_err <= 1'b1;
            wdog    <= '0;
            if (ownerData) begin
              data_rdata <= '0;
              data_ok    <= 1'b1;
            end else begin
              inst_rdata <= '0;
              inst_ok    <= 1'b1;
            end
            state <= IDLE;
          end else begin
            wdog <= wdogNext;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the pipeline's instruction-fetch port (F stage, `pcF`) and data-access port (M stage, `aluoutM`/`writedataM`) onto one shared single-outstanding memory bus. It serialises the two requesters through an FSM with one transaction in flight at a time. It also produces the stall requests that the hazard unit folds into `stallF`/`stallM`. A starvation guard and a response watchdog are included so the pipeline can never hang silently.

## Interface
Parameters:
- `MAX_DATA_RUN`, 2: consecutive data grants allowed while an instruction request waits; the next grant then goes to instruction.
- `TIMEOUT`, 255: cycles to wait for `bus_data_ok` in WAIT before aborting (counter width 8 bits).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst_req` in 1: fetch request. Held until `inst_ok`.
- `inst_addr` in 32: fetch address.
- `inst_ok` out 1: one-cycle pulse; `inst_rdata` is valid.
- `inst_rdata` out 32: fetched word.
- `data_req` in 1: data request. Held until `data_ok`.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_wsel` in 4: byte enables for stores.
- `data_addr` in 32: data address.
- `data_wdata` in 32: store data.
- `data_ok` out 1: one-cycle pulse; load data is valid or the store is complete.
- `data_rdata` out 32: load data.
- `inst_stall` out 1: `inst_req & ~inst_ok`, combinational.
- `data_stall` out 1: `data_req & ~data_ok`, combinational.
- `bus_req` out 1: address phase valid.
- `bus_wr` out 1: bus write enable.
- `bus_wsel` out 4: bus byte enables.
- `bus_addr` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_addr_ok` in 1: slave accepted the address phase.
- `bus_data_ok` in 1: slave returned data or completed the write.
- `bus_rdata` in 32: bus read data.
- `bus_err` out 1: one-cycle pulse when the watchdog fires.

## Operation
- The FSM has four states: IDLE, ADDR, WAIT, RESP. An owner register records which requester holds the bus: INST or DATA.
- **IDLE:** if either request is asserted, pick a winner and latch its address, wdata, wr and wsel into holding registers. Go to ADDR.
  - Data has priority.
  - Exception: instruction wins when `inst_req`=1 and `data_run`=`MAX_DATA_RUN`.
- **data_run counter:** increments on each data grant made while `inst_req`=1. Clears on any instruction grant and whenever `inst_req`=0 in IDLE. Saturates at `MAX_DATA_RUN`.
- **ADDR:** `bus_req`=1 and bus_* are driven from the holding registers. On `bus_addr_ok`, go to WAIT.
- **WAIT:** `bus_req`=0. The watchdog counter increments each cycle.
  - On `bus_data_ok`: capture `bus_rdata` into the owner's rdata register and go to RESP.
  - If the counter reaches `TIMEOUT` first: pulse `bus_err`, pulse the owner's ok with rdata=0, and go to IDLE.
- **RESP:** pulse the owner's ok for exactly one cycle. Requests are ignored in this state. Return to IDLE.
- A request still asserted in IDLE after its ok pulse is treated as a new request. Requesters must deassert in the cycle after ok.
- `bus_data_ok` outside WAIT is ignored. `bus_addr_ok` outside ADDR is ignored.
- The watchdog counter clears on entry to WAIT.
- **Reset** (`rst`=0, at any time, including mid-transaction):
  - State returns to IDLE; the transaction is dropped and no ok pulse is issued.
  - Outputs: `bus_req`=0, `bus_wr`=0, `bus_wsel`=0, `bus_addr`=0, `bus_wdata`=0, `inst_ok`=0, `data_ok`=0, `inst_rdata`=0, `data_rdata`=0, `bus_err`=0.
  - `data_run`=0 and the watchdog counter is 0.

## Timing
- Best-case latency: request seen in IDLE at cycle 0.
  - Cycle 1: ADDR, with `bus_addr_ok` the same cycle.
  - Cycle 2: WAIT, with `bus_data_ok`.
  - Cycle 3: RESP, ok=1.
  - Cycle 4: IDLE again.
- Minimum spacing between ok pulses is 4 cycles.
- bus_* outputs are registered and stay stable for the whole ADDR state.
- `inst_stall`/`data_stall` are asserted from the request cycle through the cycle before ok, and drop in the ok cycle.
- Simultaneous `inst_req` and `data_req` in IDLE: data is granted, unless the starvation rule applies.

## Test plan
- **Single load:** `data_req`=1, `data_addr`=0x1000_0004, slave gives addr_ok at once and data_ok one cycle later with 0xDEAD_BEEF → `bus_addr`=0x1000_0004 in ADDR; `data_ok` pulses in cycle 3 with `data_rdata`=0xDEAD_BEEF; `data_stall` is 1 in cycles 0–2.
- **Simultaneous requests:** `inst_req` and `data_req` both high at cycle 0 → the data transaction is issued first; `inst_ok` follows 4 cycles after `data_ok`.
- **Starvation:** `data_req` held continuously and re-asserted after each ok, `inst_req` held, `MAX_DATA_RUN`=2 → the grant order is D, D, I, D, D, I.
- **Store:** `data_wr`=1, `data_wsel`=4'b0011, `data_wdata`=0x1234_5678 → bus carries the same values in ADDR; slave stalls addr_ok 3 cycles → ADDR lasts 4 cycles with bus_* held stable.
- **Watchdog:** slave never returns `bus_data_ok`, `TIMEOUT`=8 → `bus_err` and `inst_ok` pulse together after 8 WAIT cycles; `inst_rdata`=0; FSM returns to IDLE.
- **Reset mid-transaction:** `rst` low during WAIT → outputs are at reset values immediately; no ok pulse; after release, a new request completes normally.
